ipsl_pcie_dma_cpld_rx_ctrl: RTL

Receive-side completion handler for the PCIe DMA read path. It consumes the 128-bit AXI-stream TLP output of the PCIe core and accepts only completion TLPs (CplD/Cpl); all other TLPs are dropped. It realigns completion payload from the 3DW-header offset into packed 128-bit words for the DMA write buffer. It returns each tag to the MRd transmit controller once the last completion for that tag has been consumed.

---
 rtl/ipsl_pcie_dma_cpld_rx_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ipsl_pcie_dma_cpld_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ipsl_pcie_dma_cpld_rx_ctrl
//  Purpose  : Receive-side completion handler for the PCIe DMA read path.
//             Accepts CplD/Cpl TLPs from the 128-bit core RX stream, drops
//             everything else, realigns CplD payload from the 3DW-header
//             offset into packed 128-bit words and releases read tags once
//             the final completion for a tag has been consumed.
//  Ports    : clk, rst                 - user clock, async active-high reset
//             i_axis_master_*          - TLP stream in (tvld/trdy/tdata/tlast)
//             o_wr_* / i_wr_rdy        - packed payload out (single register)
//             o_cpld_rcv/o_cpld_tag    - tag release pulse and tag
//             o_cpl_err                - completion status error, with release
//             i_rx_restart/o_cpld_sum  - debug completion counter and clear
//  Revision : 1.0 - initial release
// ============================================================================
module ipsl_pcie_dma_cpld_rx_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_axis_master_tvld,
    output logic         o_axis_master_trdy,
    input  logic [127:0] i_axis_master_tdata,
    input  logic         i_axis_master_tlast,
    output logic         o_wr_vld,
    input  logic         i_wr_rdy,
    output logic [127:0] o_wr_data,
    output logic [3:0]   o_wr_dw_vld,
    output logic [7:0]   o_wr_tag,
    output logic         o_wr_last,
    output logic         o_cpld_rcv,
    output logic [7:0]   o_cpld_tag,
    output logic         o_cpl_err,
    input  logic         i_rx_restart,
    output logic [13:0]  o_cpld_sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_FLUSH = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    localparam logic [7:0] C_FMT_CPLD = 8'h4A;
    localparam logic [7:0] C_FMT_CPL  = 8'h0A;

    state_t        r_state;
    state_t        w_state_nxt;

    // Per-TLP context captured from the CplD header
    logic [31:0]   r_carry;
    logic [10:0]   r_dw_remain;
    logic [7:0]    r_tag;
    logic          r_rel;
    logic          r_err;
    logic          r_flush_ld;

    // Release attributes travelling with the word in the output register,
    // so a new header may overwrite the per-TLP context while the last word
    // of the previous completion is still waiting for acceptance.
    logic          r_wr_rel;
    logic          r_wr_err;

    // A Cpl release colliding with a CplD last-word release is deferred here
    logic          r_pend;
    logic [7:0]    r_pend_tag;
    logic          r_pend_err;

    // Header decode
    logic [7:0]    w_fmt;
    logic [9:0]    w_hdr_len;
    logic [2:0]    w_hdr_status;
    logic [11:0]   w_hdr_bc;
    logic [7:0]    w_hdr_tag;
    logic [31:0]   w_hdr_dw3;
    logic [10:0]   w_len_dw;
    logic [12:0]   w_bc_bytes;
    logic          w_is_cpld;
    logic          w_is_cpl;
    logic          w_hdr_err;
    logic          w_hdr_rel;

    logic          w_out_free;
    logic          w_acc;
    logic          w_wr_hs;
    logic          w_wr_rel_evt;

    // Next-state / load controls
    logic          w_trdy;
    logic          w_load;
    logic [127:0]  w_ld_data;
    logic [3:0]    w_ld_mask;
    logic          w_ld_last;
    logic [7:0]    w_ld_tag;
    logic          w_ld_rel;
    logic          w_ld_err;
    logic          w_hdr_cpld_acc;
    logic          w_hdr_cmpl_acc;
    logic          w_dat_acc;
    logic          w_cpl_rel;

    assign w_fmt        = i_axis_master_tdata[31:24];
    assign w_hdr_len    = i_axis_master_tdata[9:0];
    assign w_hdr_status = i_axis_master_tdata[47:45];
    assign w_hdr_bc     = i_axis_master_tdata[43:32];
    assign w_hdr_tag    = i_axis_master_tdata[79:72];
    assign w_hdr_dw3    = i_axis_master_tdata[127:96];

    // Zero encodes the maximum for both length and byte count
    assign w_len_dw     = (w_hdr_len == 10'd0) ? 11'd1024 : {1'b0, w_hdr_len};
    assign w_bc_bytes   = (w_hdr_bc == 12'd0) ? 13'd4096 : {1'b0, w_hdr_bc};

    assign w_is_cpld    = (w_fmt == C_FMT_CPLD);
    assign w_is_cpl     = (w_fmt == C_FMT_CPL);
    assign w_hdr_err    = (w_hdr_status != 3'd0);
    // Final completion when the remaining byte count fits in this TLP
    assign w_hdr_rel    = (w_bc_bytes <= {w_len_dw, 2'b00}) | w_hdr_err;

    assign w_out_free   = ~o_wr_vld | i_wr_rdy;
    assign w_acc        = i_axis_master_tvld & w_trdy;
    assign w_wr_hs      = o_wr_vld & i_wr_rdy;
    assign w_wr_rel_evt = w_wr_hs & o_wr_last & r_wr_rel;

    assign o_axis_master_trdy = w_trdy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, ready and output-word load
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_trdy         = 1'b0;
        w_load         = 1'b0;
        w_ld_data      = 128'd0;
        w_ld_mask      = 4'd0;
        w_ld_last      = 1'b0;
        w_ld_tag       = r_tag;
        w_ld_rel       = r_rel;
        w_ld_err       = r_err;
        w_hdr_cpld_acc = 1'b0;
        w_hdr_cmpl_acc = 1'b0;
        w_dat_acc      = 1'b0;
        w_cpl_rel      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Only a CplD header can load the output register
                w_trdy = ~r_pend & (w_is_cpld ? w_out_free : 1'b1);
                if (w_acc) begin
                    if (w_is_cpld) begin
                        w_hdr_cpld_acc = 1'b1;
                        w_hdr_cmpl_acc = 1'b1;
                        if (w_len_dw == 11'd1) begin
                            // Whole payload is DW3 of the header beat
                            w_load      = 1'b1;
                            w_ld_data   = {96'd0, w_hdr_dw3};
                            w_ld_mask   = 4'b0001;
                            w_ld_last   = 1'b1;
                            w_ld_tag    = w_hdr_tag;
                            w_ld_rel    = w_hdr_rel;
                            w_ld_err    = w_hdr_err;
                            w_state_nxt = S_FLUSH;
                        end else if (!i_axis_master_tlast) begin
                            w_state_nxt = S_DATA;
                        end
                    end else if (w_is_cpl) begin
                        w_hdr_cmpl_acc = 1'b1;
                        w_cpl_rel      = 1'b1;
                        if (!i_axis_master_tlast) begin
                            w_state_nxt = S_DROP;
                        end
                    end else if (!i_axis_master_tlast) begin
                        w_state_nxt = S_DROP;
                    end
                end
            end

            S_DATA: begin
                w_trdy = w_out_free;
                if (w_acc) begin
                    w_dat_acc = 1'b1;
                    w_load    = 1'b1;
                    w_ld_data = {i_axis_master_tdata[95:0], r_carry};
                    w_ld_mask = 4'b1111;
                    if (i_axis_master_tlast) begin
                        if (r_dw_remain >= 11'd4) begin
                            // Top DW of this beat is left in the carry
                            w_state_nxt = S_FLUSH;
                        end else begin
                            w_ld_last   = 1'b1;
                            w_state_nxt = S_IDLE;
                            case (r_dw_remain[1:0])
                                2'd0:    w_ld_mask = 4'b0001;
                                2'd1:    w_ld_mask = 4'b0011;
                                2'd2:    w_ld_mask = 4'b0111;
                                default: w_ld_mask = 4'b1111;
                            endcase
                        end
                    end
                end
            end

            S_FLUSH: begin
                w_trdy = 1'b0;
                if (!r_flush_ld) begin
                    if (w_out_free) begin
                        w_load    = 1'b1;
                        w_ld_data = {96'd0, r_carry};
                        w_ld_mask = 4'b0001;
                        w_ld_last = 1'b1;
                    end
                end else if (w_wr_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_trdy = 1'b1;
                if (w_acc && i_axis_master_tlast) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output word register and per-TLP context
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wr_vld    <= 1'b0;
            o_wr_data   <= 128'd0;
            o_wr_dw_vld <= 4'd0;
            o_wr_tag    <= 8'd0;
            o_wr_last   <= 1'b0;
            r_wr_rel    <= 1'b0;
            r_wr_err    <= 1'b0;
            r_carry     <= 32'd0;
            r_dw_remain <= 11'd0;
            r_tag       <= 8'd0;
            r_rel       <= 1'b0;
            r_err       <= 1'b0;
            r_flush_ld  <= 1'b0;
        end else begin
            if (w_wr_hs) begin
                o_wr_vld <= 1'b0;
            end
            if (w_load) begin
                o_wr_vld    <= 1'b1;
                o_wr_data   <= w_ld_data;
                o_wr_dw_vld <= w_ld_mask;
                o_wr_tag    <= w_ld_tag;
                o_wr_last   <= w_ld_last;
                r_wr_rel    <= w_ld_rel;
                r_wr_err    <= w_ld_err;
            end

            if (w_hdr_cpld_acc) begin
                r_carry     <= w_hdr_dw3;
                r_dw_remain <= w_len_dw - 11'd1;
                r_tag       <= w_hdr_tag;
                r_rel       <= w_hdr_rel;
                r_err       <= w_hdr_err;
            end else if (w_dat_acc) begin
                r_carry     <= i_axis_master_tdata[127:96];
                r_dw_remain <= (r_dw_remain >= 11'd4) ? (r_dw_remain - 11'd4) : 11'd0;
            end

            // Set once the last (flush) word sits in the output register
            r_flush_ld <= (w_state_nxt == S_FLUSH) & (r_flush_ld | (w_load & w_ld_last));
        end
    end

    // ------------------------------------------------------------------
    // Tag release
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cpld_rcv <= 1'b0;
            o_cpld_tag <= 8'd0;
            o_cpl_err  <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_tag <= 8'd0;
            r_pend_err <= 1'b0;
        end else begin
            o_cpld_rcv <= 1'b0;
            o_cpl_err  <= 1'b0;
            if (w_wr_rel_evt) begin
                o_cpld_rcv <= 1'b1;
                o_cpld_tag <= o_wr_tag;
                o_cpl_err  <= r_wr_err;
                if (w_cpl_rel) begin
                    r_pend     <= 1'b1;
                    r_pend_tag <= w_hdr_tag;
                    r_pend_err <= w_hdr_err;
                end
            end else if (w_cpl_rel) begin
                o_cpld_rcv <= 1'b1;
                o_cpld_tag <= w_hdr_tag;
                o_cpl_err  <= w_hdr_err;
            end else if (r_pend) begin
                o_cpld_rcv <= 1'b1;
                o_cpld_tag <= r_pend_tag;
                o_cpl_err  <= r_pend_err;
                r_pend     <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Debug completion counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_cpld_sum <= 14'd0;
        end else if (i_rx_restart) begin
            o_cpld_sum <= 14'd0;
        end else if (w_hdr_cmpl_acc) begin
            o_cpld_sum <= o_cpld_sum + 14'd1;
        end
    end

endmodule
`default_nettype wire
